regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-port register-file write arbiter.
// Requester 0 (pipeline writeback) and requester 1 (mult/div unit) compete for
// one register-file write port. Ties are decided round-robin; a single requester
// is always granted. The accepted write is registered and appears one cycle later.
// Writes to address 0 are accepted but never reach the register file.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   reqN_valid/addr/data  requester N write request
//   reqN_ready            requester N accepted this cycle (combinational)
//   wr_enable/addr/data   registered register-file write port
//   conflict_count        saturating count of cycles with both requesters valid
module regfile_write_arbiter #(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned ADDR_WIDTH    = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [ADDR_WIDTH-1:0]    req0_addr,
    input  logic [REGISTER_SIZE-1:0] req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDR_WIDTH-1:0]    req1_addr,
    input  logic [REGISTER_SIZE-1:0] req1_data,
    output logic                     req1_ready,
    output logic                     wr_enable,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [REGISTER_SIZE-1:0] wr_data,
    output logic [7:0]               conflict_count
);

    typedef enum logic [0:0] {StPri0, StPri1} pri_e;

    pri_e                     pri_q, pri_d;
    logic                     wr_enable_q, wr_enable_d;
    logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
    logic [REGISTER_SIZE-1:0] wr_data_q, wr_data_d;
    logic [7:0]               conflict_count_q, conflict_count_d;
    logic                     grant0, grant1;
    logic [ADDR_WIDTH-1:0]    sel_addr;
    logic [REGISTER_SIZE-1:0] sel_data;

    // Grant decode; readies are forced low while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset) begin
            if (req0_valid && (!req1_valid || pri_q == StPri0)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        sel_addr = grant1 ? req1_addr : req0_addr;
        sel_data = grant1 ? req1_data : req0_data;
    end

    always_comb begin
        pri_d            = pri_q;
        wr_enable_d      = 1'b0;
        wr_addr_d        = wr_addr_q;
        wr_data_d        = wr_data_q;
        conflict_count_d = conflict_count_q;

        // After any grant, favour the port that did not win.
        if (grant0) begin
            pri_d = StPri1;
        end else if (grant1) begin
            pri_d = StPri0;
        end

        // Address 0 is accepted but dropped; the write port keeps its old values.
        if ((grant0 || grant1) && sel_addr != '0) begin
            wr_enable_d = 1'b1;
            wr_addr_d   = sel_addr;
            wr_data_d   = sel_data;
        end

        if (req0_valid && req1_valid && conflict_count_q != 8'hFF) begin
            conflict_count_d = conflict_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pri_q            <= StPri0;
            wr_enable_q      <= 1'b0;
            wr_addr_q        <= '0;
            wr_data_q        <= '0;
            conflict_count_q <= 8'd0;
        end else begin
            pri_q            <= pri_d;
            wr_enable_q      <= wr_enable_d;
            wr_addr_q        <= wr_addr_d;
            wr_data_q        <= wr_data_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    assign wr_enable      = wr_enable_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign conflict_count = conflict_count_q;

endmodule
